// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one FIFO write port between NUM_REQ producers,
// granting one producer at a time for a burst of up to BURST_MAX words.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      fifo_wren,
    output logic [DATA_W-1:0]         fifo_data,
    input  logic                      fifo_full
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [NUM_REQ-1:0] grant_r;
    logic [NUM_REQ-1:0] grant_nxt_s;
    logic               busy_r;
    logic [PTR_W-1:0]   owner_r;
    logic [PTR_W-1:0]   owner_nxt_s;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [PTR_W-1:0]   rr_ptr_nxt_s;
    logic [CNT_W-1:0]   burst_cnt_r;
    logic [CNT_W-1:0]   burst_cnt_nxt_s;
    logic [PTR_W-1:0]   cand_s;
    logic [PTR_W-1:0]   pick_idx_s;
    logic               pick_found_s;
    logic               owner_ack_s;
    logic               release_s;

    // Round-robin pick: scan downwards so the requester closest at/after rr_ptr wins.
    always_comb begin
        pick_found_s = |req;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s     = PTR_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            pick_idx_s = req[cand_s] ? cand_s : pick_idx_s;
        end
    end

    // Owner handshake and burst termination.
    always_comb begin
        owner_ack_s = ack[owner_r];
        release_s   = (owner_ack_s & (req_last[owner_r] |
                       (burst_cnt_r == CNT_W'(BURST_MAX - 1)))) | ~req[owner_r];
    end

    // State, grant, pointer and burst counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            busy_r      <= 1'b0;
            owner_r     <= '0;
            rr_ptr_r    <= '0;
            burst_cnt_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            grant_r     <= grant_nxt_s;
            busy_r      <= (state_nxt_s == BUSY);
            owner_r     <= owner_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
        end
    end

    // Next-state logic; a release always returns to IDLE, giving one idle cycle between grants.
    always_comb begin
        state_nxt_s     = state_r;
        grant_nxt_s     = grant_r;
        owner_nxt_s     = owner_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        burst_cnt_nxt_s = burst_cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s              = BUSY;
                    grant_nxt_s              = '0;
                    grant_nxt_s[pick_idx_s]  = 1'b1;
                    owner_nxt_s              = pick_idx_s;
                    burst_cnt_nxt_s          = '0;
                end else begin
                    grant_nxt_s = '0;
                end
            end
            BUSY: begin
                if (release_s) begin
                    state_nxt_s     = IDLE;
                    grant_nxt_s     = '0;
                    burst_cnt_nxt_s = '0;
                    rr_ptr_nxt_s    = (owner_r == PTR_W'(NUM_REQ - 1)) ? '0
                                                                        : owner_r + PTR_W'(1);
                end else if (owner_ack_s) begin
                    burst_cnt_nxt_s = burst_cnt_r + CNT_W'(1);
                end else begin
                    burst_cnt_nxt_s = burst_cnt_r;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                grant_nxt_s     = '0;
                burst_cnt_nxt_s = '0;
            end
        endcase
    end

    // Write-port outputs; everything is gated by the registered grant.
    always_comb begin
        ack       = grant_r & req & {NUM_REQ{~fifo_full}};
        fifo_wren = |ack;
        if (|grant_r) begin
            fifo_data = req_data[owner_r*DATA_W +: DATA_W];
        end else begin
            fifo_data = '0;
        end
    end

    assign grant = grant_r;
    assign busy  = busy_r;

endmodule
